// File: rtl/cpu6_bus_if.sv
// Byte-wide memory bus between the cpu6 core and its synchronous RAM.
// Read data arrives one cycle after the address; writes land on the
// rising edge where write_en is high.
`timescale 1ns/1ps
interface cpu6_bus_if;
  logic [7:0]  data_in;
  logic        write_en;
  logic [15:0] address;
  logic [7:0]  data_out;

  modport master (input data_in, output write_en, output address, output data_out);
  modport slave  (output data_in, input write_en, input address, input data_out);
endinterface

// File: rtl/cpu6_core.sv
// Simplified 8-bit CPU6-style core: multi-cycle fetch/decode/execute over a
// synchronous byte memory. All I/O is done with memory-mapped stores.
// For 16-bit operand instructions the second operand byte is consumed
// directly on the data bus in EXEC, so the combined operand is
// {opr_hi_q, data_in} there; this keeps JMP/LDX/STAL at 4 cycles and
// LDAL abs at 5.
`timescale 1ns/1ps
module cpu6_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic       clock,
  input  logic       reset,
  cpu6_bus_if.master bus
);

  localparam logic [7:0] OP_HLT   = 8'h00;
  localparam logic [7:0] OP_NOP   = 8'h01;
  localparam logic [7:0] OP_BZ    = 8'h14;
  localparam logic [7:0] OP_BNZ   = 8'h15;
  localparam logic [7:0] OP_INAL  = 8'h28;
  localparam logic [7:0] OP_DCAL  = 8'h29;
  localparam logic [7:0] OP_LDX   = 8'h60;
  localparam logic [7:0] OP_JMP   = 8'h71;
  localparam logic [7:0] OP_LDALI = 8'h80;
  localparam logic [7:0] OP_LDALA = 8'h81;
  localparam logic [7:0] OP_LDALX = 8'h86;
  localparam logic [7:0] OP_STAL  = 8'hA1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_OP1,
    S_EXEC,
    S_MEMRD,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  al_q, al_d;
  logic [15:0] x_q, x_d;
  logic        z_q, z_d;
  logic        n_q, n_d;
  logic [7:0]  ir_q, ir_d;
  logic [7:0]  opr_hi_q, opr_hi_d;

  logic               al_wr;
  logic signed [15:0] rel_s;
  logic [15:0]        operand;
  logic [15:0]        mem_addr;
  logic               mem_we;
  logic [7:0]         mem_wdata;

  // Architectural state; reset aborts any instruction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      al_q     <= 8'h00;
      x_q      <= 16'h0000;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      ir_q     <= 8'h00;
      opr_hi_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      al_q     <= al_d;
      x_q      <= x_d;
      z_q      <= z_d;
      n_q      <= n_d;
      ir_q     <= ir_d;
      opr_hi_q <= opr_hi_d;
    end
  end

  // Next-state, register updates and bus drive for the current cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    al_d      = al_q;
    x_d       = x_q;
    z_d       = z_q;
    n_d       = n_q;
    ir_d      = ir_q;
    opr_hi_d  = opr_hi_q;
    al_wr     = 1'b0;
    rel_s     = {{8{bus.data_in[7]}}, bus.data_in};
    operand   = {opr_hi_q, bus.data_in};
    mem_addr  = pc_q;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;

    case (state_q)
      S_FETCH: begin
        mem_addr = pc_q;
        pc_d     = pc_q + 16'd1;
        state_d  = S_DECODE;
      end

      S_DECODE: begin
        ir_d = bus.data_in;
        case (bus.data_in)
          OP_HLT:  state_d = S_HALT;
          OP_NOP:  state_d = S_FETCH;
          OP_INAL: begin
            al_d    = al_q + 8'd1;
            al_wr   = 1'b1;
            state_d = S_FETCH;
          end
          OP_DCAL: begin
            al_d    = al_q - 8'd1;
            al_wr   = 1'b1;
            state_d = S_FETCH;
          end
          OP_LDALX: begin
            mem_addr = x_q;
            x_d      = x_q + 16'd1;
            state_d  = S_MEMRD;
          end
          OP_BZ, OP_BNZ, OP_LDX, OP_JMP, OP_LDALI, OP_LDALA, OP_STAL: begin
            mem_addr = pc_q;
            pc_d     = pc_q + 16'd1;
            state_d  = S_OP1;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_OP1: begin
        opr_hi_d = bus.data_in;
        case (ir_q)
          OP_BZ: begin
            if (z_q) pc_d = pc_q + $unsigned(rel_s);
            state_d = S_FETCH;
          end
          OP_BNZ: begin
            if (!z_q) pc_d = pc_q + $unsigned(rel_s);
            state_d = S_FETCH;
          end
          OP_LDALI: begin
            al_d    = bus.data_in;
            al_wr   = 1'b1;
            state_d = S_FETCH;
          end
          default: begin
            mem_addr = pc_q;
            pc_d     = pc_q + 16'd1;
            state_d  = S_EXEC;
          end
        endcase
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_q)
          OP_LDX: x_d = operand;
          OP_JMP: pc_d = operand;
          OP_LDALA: begin
            mem_addr = operand;
            state_d  = S_MEMRD;
          end
          OP_STAL: begin
            mem_addr  = operand;
            mem_we    = 1'b1;
            mem_wdata = al_q;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMRD: begin
        al_d    = bus.data_in;
        al_wr   = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: state_d = S_HALT;

      default: state_d = S_FETCH;
    endcase

    if (al_wr) begin
      z_d = (al_d == 8'h00);
      n_d = al_d[7];
    end
  end

  assign bus.address  = mem_addr;
  assign bus.write_en = mem_we;
  assign bus.data_out = mem_wdata;

endmodule

// File: tb/tb_cpu6_core.sv
// Directed and randomized programs run on cpu6_core; an instruction-level
// reference model predicts stores (address, data, cycle) and final state.
`timescale 1ns/1ps
module tb_cpu6_core;
  typedef logic [7:0] bq_t[$];

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cpu6_bus_if bus();
  cpu6_core #(.RESET_PC(16'h0000)) dut (.clock(clock), .reset(reset), .bus(bus));

  // Memory: program image written by the stimulus, store overlay written by the bus.
  logic [7:0]  img  [65536];
  logic [7:0]  wmem [65536];
  int          wgen [65536];
  int          gen = 0;
  int          cyc = 0;
  int          wcount = 0;
  int          we_pulses = 0;
  logic [15:0] log_a [64];
  logic [7:0]  log_d [64];
  int          log_c [64];

  int checks = 0;
  int errors = 0;

  always @(posedge clock) begin
    bus.data_in <= (wgen[bus.address] == gen) ? wmem[bus.address] : img[bus.address];
    if (bus.write_en) begin
      wmem[bus.address] <= bus.data_out;
      wgen[bus.address] <= gen;
      we_pulses <= we_pulses + 1;
    end
    if (reset) begin
      cyc    <= 0;
      wcount <= 0;
    end else begin
      cyc <= cyc + 1;
      if (bus.write_en && wcount < 64) begin
        log_a[wcount] <= bus.address;
        log_d[wcount] <= bus.data_out;
        log_c[wcount] <= cyc;
        wcount <= wcount + 1;
      end
    end
  end

  function automatic logic [7:0] peek(input logic [15:0] a);
    return (wgen[a] == gen) ? wmem[a] : img[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: executes whole instructions with the documented cycle costs.
  logic [7:0]  rw [int];
  logic [15:0] e_a[$];
  logic [7:0]  e_d[$];
  int          e_c[$];
  logic [15:0] r_pc, r_x;
  logic [7:0]  r_al;
  logic        r_z, r_n;
  int          r_t;

  function automatic logic [7:0] rrd(input logic [15:0] a);
    return rw.exists(int'(a)) ? rw[int'(a)] : img[a];
  endfunction

  task automatic ref_run();
    logic [15:0] pc, x, a;
    logic [7:0]  al, op, b;
    logic        z, n, done;
    int          t;
    rw.delete(); e_a.delete(); e_d.delete(); e_c.delete();
    pc = 16'h0000; x = 16'h0000; al = 8'h00; z = 1'b0; n = 1'b0; t = 0; done = 1'b0;
    for (int s = 0; s < 4000 && !done; s++) begin
      op = rrd(pc);
      pc = pc + 16'd1;
      case (op)
        8'h00: begin t += 2; done = 1'b1; end
        8'h28: begin al = al + 8'd1; z = (al == 8'h00); n = al[7]; t += 2; end
        8'h29: begin al = al - 8'd1; z = (al == 8'h00); n = al[7]; t += 2; end
        8'h80: begin al = rrd(pc); pc = pc + 16'd1; z = (al == 8'h00); n = al[7]; t += 3; end
        8'h81: begin
          a = {rrd(pc), rrd(pc + 16'd1)}; pc = pc + 16'd2;
          al = rrd(a); z = (al == 8'h00); n = al[7]; t += 5;
        end
        8'h86: begin al = rrd(x); x = x + 16'd1; z = (al == 8'h00); n = al[7]; t += 3; end
        8'h60: begin x = {rrd(pc), rrd(pc + 16'd1)}; pc = pc + 16'd2; t += 4; end
        8'h71: begin pc = {rrd(pc), rrd(pc + 16'd1)}; t += 4; end
        8'hA1: begin
          a = {rrd(pc), rrd(pc + 16'd1)}; pc = pc + 16'd2;
          rw[int'(a)] = al;
          e_a.push_back(a); e_d.push_back(al); e_c.push_back(t + 3);
          t += 4;
        end
        8'h14, 8'h15: begin
          b = rrd(pc); pc = pc + 16'd1;
          if ((op == 8'h14) == z) pc = 16'(int'(pc) + int'($signed(b)));
          t += 3;
        end
        default: t += 2;
      endcase
    end
    r_pc = pc; r_x = x; r_al = al; r_z = z; r_n = n; r_t = t;
  endtask

  task automatic begin_prog();
    @(negedge clock);
    reset = 1'b1;
    gen = gen + 1;
    for (int i = 0; i < 65536; i++) img[i] = 8'h00;
    for (int i = 0; i < 256; i++) img[16'h4000 + i] = 8'($urandom);
  endtask

  task automatic put(input logic [15:0] base, input bq_t p);
    foreach (p[i]) img[16'(int'(base) + i)] = p[i];
  endtask

  task automatic run_prog(input string name);
    int n;
    ref_run();
    #200;
    chk({name, ".rst_addr"}, 32'(bus.address), 32'h0000);
    chk({name, ".rst_we"}, 32'(bus.write_en), 32'h0);
    chk({name, ".rst_dout"}, 32'(bus.data_out), 32'h00);
    chk({name, ".rst_regs"}, {8'(dut.al_q), 16'(dut.x_q), 6'h0, dut.z_q, dut.n_q}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    repeat (r_t + 12) @(posedge clock);
    @(negedge clock);
    chk({name, ".nwr"}, 32'(wcount), 32'(e_a.size()));
    n = (wcount < e_a.size()) ? wcount : e_a.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s.wa%0d", name, i), 32'(log_a[i]), 32'(e_a[i]));
      chk($sformatf("%s.wd%0d", name, i), 32'(log_d[i]), 32'(e_d[i]));
      chk($sformatf("%s.wc%0d", name, i), 32'(log_c[i]), 32'(e_c[i]));
    end
    chk({name, ".pc"}, 32'(dut.pc_q), 32'(r_pc));
    chk({name, ".al"}, 32'(dut.al_q), 32'(r_al));
    chk({name, ".x"}, 32'(dut.x_q), 32'(r_x));
    chk({name, ".zn"}, {30'h0, dut.z_q, dut.n_q}, {30'h0, r_z, r_n});
    chk({name, ".halt_we"}, 32'(bus.write_en), 32'h0);
  endtask

  task automatic gen_random(output bq_t p);
    int k;
    logic [7:0] r;
    p.delete();
    for (int i = 0; i < 28; i++) begin
      k = $urandom_range(0, 10);
      r = 8'($urandom);
      case (k)
        0: p.push_back(($urandom_range(0, 1) == 1) ? 8'h01 : 8'($urandom_range(2, 19)));
        1: p.push_back(8'h28);
        2: p.push_back(8'h29);
        3: begin p.push_back(8'h80); p.push_back(r); end
        4: begin p.push_back(8'h60); p.push_back(8'h40); p.push_back(8'($urandom_range(0, 240))); end
        5: p.push_back(8'h86);
        6: begin p.push_back(8'h81); p.push_back(8'h40); p.push_back(r); end
        7: begin p.push_back(8'hA1); p.push_back(8'h40); p.push_back(r); end
        8: begin
          p.push_back(($urandom_range(0, 1) == 1) ? 8'h14 : 8'h15);
          p.push_back(($urandom_range(0, 1) == 1) ? 8'h02 : 8'h00);
          p.push_back(8'h80); p.push_back(r);
        end
        9: begin p.push_back(8'hA1); p.push_back(8'h5A); p.push_back(8'h00); end
        default: begin
          k = p.size() + 3;
          p.push_back(8'h71); p.push_back(8'(k >> 8)); p.push_back(8'(k));
        end
      endcase
    end
    p.push_back(8'hA1); p.push_back(8'h5A); p.push_back(8'h00);
    p.push_back(8'h00);
  endtask

  initial begin
    bq_t p;
    string s;
    logic [7:0] bx [6];
    logic [7:0] keep;
    int base;

    // Reset and single store.
    begin_prog();
    p = {8'h80, 8'h48, 8'hA1, 8'h5A, 8'h00, 8'h00};
    put(16'h0000, p);
    run_prog("store");
    chk("store.cnt", 32'(wcount), 32'd1);
    chk("store.addr", 32'(log_a[0]), 32'h5A00);
    chk("store.data", 32'(log_d[0]), 32'h48);

    // String output loop.
    begin_prog();
    p = {8'h60, 8'h00, 8'h40, 8'h86, 8'h14, 8'h06, 8'hA1, 8'h5A, 8'h00,
         8'h71, 8'h00, 8'h03, 8'h80, 8'h5A, 8'hA1, 8'h5B, 8'h00, 8'h00};
    put(16'h0000, p);
    p = {8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h52, 8'h4C, 8'h44, 8'h21, 8'h00};
    put(16'h0040, p);
    run_prog("hello");
    s = "HELLORLD!";
    chk("hello.cnt", 32'(wcount), 32'd10);
    for (int i = 0; i < 9; i++) chk($sformatf("hello.ch%0d", i), 32'(log_d[i]), 32'(s[i]));
    chk("hello.stop", {8'h0, log_a[9], log_d[9]}, 32'h005B005A);

    // Countdown loop with BNZ.
    begin_prog();
    p = {8'h80, 8'h05, 8'h29, 8'hA1, 8'h5A, 8'h00, 8'h15, 8'hFA,
         8'h80, 8'h5A, 8'hA1, 8'h5B, 8'h00, 8'h00};
    put(16'h0000, p);
    run_prog("bnz");
    bx = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h5A};
    for (int i = 0; i < 6; i++) chk($sformatf("bnz.d%0d", i), 32'(log_d[i]), 32'(bx[i]));

    // Flags and AL wrap, both branch polarities.
    begin_prog();
    p = {8'h80, 8'h00, 8'h29, 8'hA1, 8'h40, 8'h00, 8'h15, 8'h02, 8'h80, 8'h11,
         8'h28, 8'hA1, 8'h40, 8'h01, 8'h14, 8'h02, 8'h80, 8'h22, 8'h15, 8'h02,
         8'hA1, 8'h40, 8'h02, 8'h00};
    put(16'h0000, p);
    run_prog("flags");
    chk("flags.d0", 32'(log_d[0]), 32'hFF);
    chk("flags.d1", 32'(log_d[1]), 32'h00);
    chk("flags.d2", 32'(log_d[2]), 32'h00);
    chk("flags.z", 32'(dut.z_q), 32'h1);

    // PC wrap through 0xFFFF during operand fetch.
    begin_prog();
    p = {8'h14, 8'h04, 8'h71, 8'hFF, 8'hFE, 8'h00, 8'hA1, 8'h5A, 8'h00, 8'h00};
    put(16'h0000, p);
    p = {8'h80, 8'h00};
    put(16'hFFFE, p);
    run_prog("wrap");
    chk("wrap.cnt", 32'(wcount), 32'd1);

    // Reset during the store cycle of STAL.
    begin_prog();
    p = {8'h80, 8'h37, 8'hA1, 8'h40, 8'h00, 8'h00};
    put(16'h0000, p);
    keep = img[16'h4000];
    #200;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk("abort.pre_we", 32'(bus.write_en), 32'h1);
    chk("abort.pre_addr", 32'(bus.address), 32'h4000);
    base = we_pulses;
    reset = 1'b1;
    #1;
    chk("abort.we", 32'(bus.write_en), 32'h0);
    chk("abort.addr", 32'(bus.address), 32'h0000);
    chk("abort.dout", 32'(bus.data_out), 32'h00);
    @(posedge clock);
    @(negedge clock);
    chk("abort.pulses", 32'(we_pulses), 32'(base));
    chk("abort.mem", 32'(peek(16'h4000)), 32'(keep));
    #200;
    @(negedge clock);
    reset = 1'b0;
    chk("abort.refetch", 32'(bus.address), 32'h0000);
    repeat (12) @(posedge clock);
    @(negedge clock);
    chk("abort.rerun_mem", 32'(peek(16'h4000)), 32'h37);
    chk("abort.rerun_pulses", 32'(we_pulses), 32'(base + 1));

    // Randomized programs, each reloaded after a fresh reset.
    for (int r = 0; r < 8; r++) begin
      begin_prog();
      gen_random(p);
      put(16'h0000, p);
      run_prog($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
